// File: rtl/UART_pkg.sv
// UART_pkg: shared byte type and arbiter state encoding
package UART_pkg;
  typedef logic [7:0] uart_data_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_LOW, ST_WAIT_HIGH} uart_arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-side signals of the arbiter
interface uart_tx_arbiter_if
  import UART_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0] req_valid;
  uart_data_t [NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  uart_data_t tx_data;
  logic send;
  logic tx_data_ready;
  logic [IDW-1:0] grant_id;
  logic locked;
  logic busy;
  modport slave (
    input req_valid, req_data, req_last, tx_data_ready,
    output req_ready, tx_data, send, grant_id, locked, busy
  );
  modport master (
    output req_valid, req_data, req_last, tx_data_ready,
    input req_ready, tx_data, send, grant_id, locked, busy
  );
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: first valid index searching upward from a pointer, wrapping
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDW-1:0]     i_ptr,
  output logic [IDW-1:0]     o_win,
  output logic               o_any
);
  logic [IDW-1:0] w_idx;
  // scan from farthest to nearest so the nearest valid index is written last
  always_comb begin
    o_win = '0;
    w_idx = '0;
    o_any = |i_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(i_ptr) + k) % NUM_REQ);
      if (i_valid[w_idx]) o_win = w_idx;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with message locking
module uart_tx_arbiter
  import UART_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.slave bus
);
  uart_arb_state_e r_state;
  logic r_send, r_busy, r_locked, r_last;
  uart_data_t r_data;
  logic [IDW-1:0] r_grant, r_ptr, w_win, w_next_ptr;
  logic [NUM_REQ-1:0] w_elig;
  logic w_any, w_take, w_xfer;

  assign w_elig = r_locked ? (bus.req_valid & (NUM_REQ'(1) << r_grant)) : bus.req_valid;

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .i_valid(w_elig),
    .i_ptr(r_ptr),
    .o_win(w_win),
    .o_any(w_any)
  );

  assign w_take = (r_state == ST_IDLE) && bus.tx_data_ready && w_any;
  assign w_xfer = (r_state == ST_SEND) && bus.tx_data_ready;
  assign w_next_ptr = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + IDW'(1);

  assign bus.req_ready = w_take ? (NUM_REQ'(1) << w_win) : '0;
  assign bus.tx_data = r_data;
  assign bus.send = r_send;
  assign bus.grant_id = r_grant;
  assign bus.locked = r_locked;
  assign bus.busy = r_busy;

  // grant/send/wait-for-frame sequencer; outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_send   <= 1'b0;
      r_busy   <= 1'b0;
      r_locked <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
      r_grant  <= '0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_take) begin
          r_state <= ST_SEND;
          r_send  <= 1'b1;
          r_busy  <= 1'b1;
          r_data  <= bus.req_data[w_win];
          r_last  <= bus.req_last[w_win];
          r_grant <= w_win;
        end
        ST_SEND: if (w_xfer) begin
          r_state  <= ST_WAIT_LOW;
          r_send   <= 1'b0;
          r_locked <= ~r_last;
          if (r_last) r_ptr <= w_next_ptr;
        end
        ST_WAIT_LOW: if (!bus.tx_data_ready) r_state <= ST_WAIT_HIGH;
        ST_WAIT_HIGH: if (bus.tx_data_ready) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: requester FIFOs, UART frame model and in-order transfer scoreboard
module tb_uart_tx_arbiter;
  import UART_pkg::*;
  localparam int N = 4;
  localparam int FRAME = 10;

  typedef struct {int r; int d; logic l; int id; logic lk;} vec_t;
  typedef struct {int id; int d; logic lk; int gap;} exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  // UART: after a transfer, ready stays high one more cycle, then low for FRAME cycles
  int cnt = 0;
  logic hold_low = 1'b0;
  always @(posedge clk) begin
    if (bus.send && bus.tx_data_ready) cnt <= FRAME + 1;
    else if (cnt > 0) cnt <= cnt - 1;
  end
  assign bus.tx_data_ready = !hold_low && (cnt == 0 || cnt == FRAME + 1);

  uart_data_t mem_d [N][16];
  logic mem_l [N][16];
  int head [N];
  int tail [N];
  logic [N-1:0] mask = '0;

  always_comb begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (head[i] != tail[i]) && !mask[i];
      bus.req_data[i] = mem_d[i][head[i] % 16];
      bus.req_last[i] = mem_l[i][head[i] % 16];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic put(input int r, input int d, input logic l);
    mem_d[r][tail[r] % 16] = uart_data_t'(d);
    mem_l[r][tail[r] % 16] = l;
    tail[r]++;
  endtask

  task automatic expect_tx(input int id, input int d, input logic lk, input int gap);
    exp_t e;
    e.id = id; e.d = d; e.lk = lk; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.busy || !bus.tx_data_ready) && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending=%0d busy=%0d", sb.size(), bus.busy);
    end
  endtask

  task automatic wait_sb_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL send_timeout: pending=%0d", sb.size());
    end
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!bus.busy && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy=%0d", bus.busy);
    end
  endtask

  // requesters pop their FIFO head when the arbiter strobes req_ready
  initial begin
    logic [N-1:0] w_pop;
    forever begin
      @(negedge clk); #2;
      w_pop = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (w_pop[i]) head[i]++;
    end
  end

  // transfer monitor: in-order compare, pulse legality, lock state, spacing
  initial begin
    int cyc = 0;
    int lastc = 0;
    bit lk_pend = 0;
    logic lk_exp = 1'b0;
    logic [N-1:0] prev = '0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (lk_pend) begin
        chk("locked_after_tx", int'(bus.locked), int'(lk_exp));
        lk_pend = 0;
      end
      if (bus.req_ready != '0) begin
        checks++;
        if (!$onehot(bus.req_ready) || (bus.req_ready & ~bus.req_valid) != '0 || (bus.req_ready & prev) != '0) begin
          errors++;
          $display("FAIL req_ready_pulse: got ready=%b valid=%b prev=%b want one-hot single-cycle on a valid", bus.req_ready, bus.req_valid, prev);
        end
      end
      prev = bus.req_ready;
      if (bus.send && bus.tx_data_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_send: got id=%0d data=%0h want no transfer", bus.grant_id, bus.tx_data);
        end else begin
          e = sb.pop_front();
          chk("grant_id", int'(bus.grant_id), e.id);
          chk("tx_data", int'(bus.tx_data), e.d);
          if (e.gap != 0) chk("send_spacing", cyc - lastc, e.gap);
          lk_pend = 1;
          lk_exp = e.lk;
        end
        lastc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[8];
    tab[0] = '{0, 8'h10, 1'b1, 0, 1'b0};
    tab[1] = '{1, 8'h20, 1'b1, 1, 1'b0};
    tab[2] = '{2, 8'h30, 1'b1, 2, 1'b0};
    tab[3] = '{3, 8'h40, 1'b1, 3, 1'b0};
    tab[4] = '{0, 8'h11, 1'b1, 0, 1'b0};
    tab[5] = '{1, 8'h21, 1'b1, 1, 1'b0};
    tab[6] = '{2, 8'h31, 1'b1, 2, 1'b0};
    tab[7] = '{3, 8'h41, 1'b1, 3, 1'b0};
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_send", int'(bus.send), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_grant_id", int'(bus.grant_id), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      put(tab[k].r, tab[k].d, tab[k].l);
      expect_tx(tab[k].id, tab[k].d, tab[k].lk, 0);
    end
    wait_drain(400);
    @(negedge clk);
    put(2, 8'h21, 1'b0); put(2, 8'h22, 1'b0); put(2, 8'h23, 1'b1);
    expect_tx(2, 8'h21, 1'b1, 0);
    expect_tx(2, 8'h22, 1'b1, 0);
    expect_tx(2, 8'h23, 1'b0, 0);
    wait_busy(20);
    @(negedge clk);
    put(0, 8'h01, 1'b1); put(1, 8'h11, 1'b1);
    expect_tx(0, 8'h01, 1'b0, 0);
    expect_tx(1, 8'h11, 1'b0, 0);
    wait_drain(300);
    @(negedge clk);
    put(2, 8'h32, 1'b0);
    expect_tx(2, 8'h32, 1'b1, 0);
    wait_drain(100);
    chk("locked_idle", int'(bus.locked), 1);
    @(negedge clk);
    mask[2] = 1'b1;
    put(2, 8'h33, 1'b1);
    put(0, 8'h02, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #3;
      chk("lock_hold_busy", int'(bus.busy), 0);
      chk("lock_hold_ready", int'(bus.req_ready), 0);
    end
    @(negedge clk);
    mask[2] = 1'b0;
    expect_tx(2, 8'h33, 1'b0, 0);
    expect_tx(0, 8'h02, 1'b0, 0);
    wait_drain(200);
    @(negedge clk);
    hold_low = 1'b1;
    put(0, 8'h03, 1'b1);
    expect_tx(0, 8'h03, 1'b0, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #3;
      chk("uart_busy_ready", int'(bus.req_ready), 0);
      chk("uart_busy_send", int'(bus.send), 0);
    end
    @(negedge clk);
    hold_low = 1'b0;
    wait_drain(100);
    @(negedge clk);
    put(1, 8'h12, 1'b1);
    expect_tx(1, 8'h12, 1'b0, 0);
    wait_sb_empty(20);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_send", int'(bus.send), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_grant_id", int'(bus.grant_id), 0);
    chk("abort_tx_data", int'(bus.tx_data), 0);
    chk("abort_locked", int'(bus.locked), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(3, 8'h34, 1'b1); put(0, 8'h04, 1'b1);
    expect_tx(0, 8'h04, 1'b0, 0);
    expect_tx(3, 8'h34, 1'b0, 0);
    wait_drain(200);
    @(negedge clk);
    put(3, 8'hA5, 1'b0); put(3, 8'h5A, 1'b1);
    expect_tx(3, 8'hA5, 1'b1, 0);
    expect_tx(3, 8'h5A, 1'b0, 14);
    wait_drain(200);
    chk("queue_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one UART transmitter (range 2..8).
REQ-002 The block SHALL have parameter IDW, default $clog2(NUM_REQ), meaning the requester-index width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-006 The block SHALL have port req_data  input  NUM_REQ x uart_data_t  per-requester byte.
REQ-007 The block SHALL have port req_last  input  NUM_REQ  per-requester flag: the byte is the final byte of its message.
REQ-008 The block SHALL have port req_ready  output  NUM_REQ  one-hot pop strobe; the byte is taken when req_valid[i] && req_ready[i].
REQ-009 The block SHALL have port tx_data  output  uart_data_t  byte to the UART transmitter.
REQ-010 The block SHALL have port send  output  1  transmit request to the UART.
REQ-011 The block SHALL have port tx_data_ready  input  1  UART idle; high means it accepts a byte.
REQ-012 The block SHALL have port grant_id  output  IDW  index of the current or most recent winner.
REQ-013 The block SHALL have port locked  output  1  high while a multi-byte message holds the grant.
REQ-014 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 A UART transfer SHALL occur on a cycle with send=1 and tx_data_ready=1; after a transfer the UART drops tx_data_ready within 1 cycle and holds it low until the frame ends.
REQ-016 The FSM SHALL have states IDLE, SEND, WAIT_LOW and WAIT_HIGH.
REQ-017 In IDLE, with tx_data_ready=1 and at least one eligible req_valid, the block SHALL:
  - pick the winner;
  - assert req_ready[winner] for exactly that cycle;
  - latch req_data/req_last of the winner into a holding register;
  - set grant_id;
  - go to SEND.
REQ-018 Eligible requesters SHALL be all requesters when locked=0, and only grant_id when locked=1.
REQ-019 The winner SHALL be chosen round-robin: the first valid index searching upward from rr_ptr, modulo NUM_REQ.
REQ-020 In SEND, the block SHALL drive send=1 and tx_data=holding register, and move to WAIT_LOW on the transfer cycle.
REQ-021 In WAIT_LOW, send SHALL be 0 and the FSM SHALL move to WAIT_HIGH when tx_data_ready=0.
REQ-022 In WAIT_HIGH, the FSM SHALL return to IDLE when tx_data_ready=1.
REQ-023 On the transfer cycle, the block SHALL set locked to the inverse of the latched last flag.
REQ-024 On the transfer cycle, if last=1, rr_ptr SHALL become (grant_id+1) mod NUM_REQ; otherwise rr_ptr SHALL be unchanged.
REQ-025 While locked=1 and req_valid[grant_id]=0, the block SHALL stay in IDLE with no grant, even if other requesters are valid.
REQ-026 req_ready SHALL be zero in every state except IDLE, and SHALL never be asserted for a requester with req_valid=0.
REQ-027 send SHALL be 1 only in SEND; tx_data SHALL hold its value from IDLE through the end of WAIT_HIGH.
REQ-028 Latency from req_valid (with the UART idle and the requester eligible) to send SHALL be 1 cycle.
REQ-029 Minimum byte-to-byte spacing SHALL be SEND + WAIT_LOW + WAIT_HIGH + IDLE = 4 cycles, plus the frame time.
REQ-030 A simultaneous change of req_valid by a non-winner during SEND or the WAIT states SHALL have no effect until IDLE.

Reset
REQ-031 While rst_n=0, the block SHALL set: state=IDLE, send=0, req_ready=0, tx_data=0, grant_id=0, locked=0, busy=0, rr_ptr=0 and holding register=0.
REQ-032 Reset asserted mid-operation SHALL abort the byte and drop send asynchronously; after reset the block SHALL NOT retry the byte.

Structure
REQ-033 The state enum uart_arb_state_e SHALL be added to UART_pkg; uart_data_t SHALL be used from UART_pkg.
REQ-034 Round-robin selection SHALL be a combinational sub-module uart_rr_pick:
  - inputs: valid vector, rr_ptr;
  - outputs: winner index, any_valid.

Verification
REQ-035 Scenario: req_valid=4'b1111, all last=1, UART model ready → grant order 0,1,2,3,0; each req_ready is a single-cycle pulse.
REQ-036 Scenario: requester 2 sends 3 bytes (last=0,0,1) while requesters 0 and 1 are valid → bytes 2,2,2 go out before any other grant; locked is 1 between them.
REQ-037 Scenario: locked=1 and requester 2 deasserts valid for 10 cycles while 0 is valid → no grant, busy=0; the grant resumes on requester 2.
REQ-038 Scenario: tx_data_ready held 0 → req_valid=4'b0001 produces no req_ready and no send.
REQ-039 Scenario: rst_n asserted in WAIT_LOW → send=0, state=IDLE, rr_ptr=0; after release, a new grant starts from requester 0.
REQ-040 Scenario: single requester 3 with back-to-back bytes 0xA5, 0x5A and a 10-cycle frame → send pulses 14 cycles apart, with tx_data matching each byte.
